adc_line_reporter: RTL and testbench

Downstream consumer of the AVR interface block. Scans the ADC channels enabled by a mask through the `channel` request, and captures the first `new_sample` whose `sample_channel` matches the requested channel. Each captured sample becomes a 7-byte ASCII line, `C:HHH\r\n`, sent through the serial Tx handshake (`tx_data`, `new_tx_data`, `tx_busy`).

---
 rtl/adc_report_pkg.sv | 34 +++
 rtl/mask_next_channel.sv | 30 +++
 rtl/adc_line_reporter.sv | 115 +++++++++++
 tb/tb_adc_line_reporter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/adc_report_pkg.sv
// Shared types, ASCII constants and helpers for the ADC line reporter.
// Lines are formatted as "C:HHH\r\n".
package adc_report_pkg;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_SEND = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam int         LINE_LEN    = 7;
    localparam logic [2:0] LAST_INDEX  = 3'(LINE_LEN - 1);

    function automatic logic [7:0] hex_ascii(input logic [3:0] d);
        if (d < 4'd10)
            return 8'h30 + {4'h0, d};
        else
            return 8'h41 + ({4'h0, d} - 8'd10);
    endfunction

    // Lowest enabled channel; 0 when the mask is empty.
    function automatic logic [3:0] lowest_channel(input logic [15:0] mask);
        logic [3:0] result;
        result = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i]) result = 4'(i);
        end
        return result;
    endfunction

endpackage

// File: rtl/mask_next_channel.sv
// Combinational search for the next enabled channel strictly above the
// current one, wrapping 15 -> 0. A single-bit mask returns the same channel.
module mask_next_channel
    import adc_report_pkg::*;
(
    input  logic [3:0]  current,
    input  logic [15:0] mask,
    output logic [3:0]  next_channel
);

    logic [3:0]  cand [16];
    logic [15:0] hit;

    // Candidate gi is current+1+gi; the last one wraps back onto current.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_cand
            assign cand[gi] = current + 4'(gi + 1);
            assign hit[gi]  = mask[cand[gi]];
        end
    endgenerate

    always_comb begin
        next_channel = current;
        for (int i = 15; i >= 0; i--) begin
            if (hit[i]) next_channel = cand[i];
        end
    end

endmodule

// File: rtl/adc_line_reporter.sv
// Captures one matching ADC sample per enabled channel and streams it out as
// a 7-byte ASCII line over the serial Tx handshake.
module adc_line_reporter
    import adc_report_pkg::*;
#(
    parameter logic [15:0] CHANNEL_MASK = 16'h0001
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    output logic [3:0] channel,
    input  logic       new_sample,
    input  logic [9:0] sample,
    input  logic [3:0] sample_channel,
    output logic [7:0] tx_data,
    output logic       new_tx_data,
    input  logic       tx_busy,
    output logic       line_active
);

    localparam logic [3:0] FIRST_CHANNEL = lowest_channel(CHANNEL_MASK);

    state_t     state_reg, state_next;
    logic [2:0] index_reg, index_next;
    logic [9:0] sample_reg, sample_next;
    logic [3:0] channel_reg, channel_next;
    logic [7:0] tx_data_reg, tx_data_next;
    logic       new_tx_data_reg, new_tx_data_next;
    logic       line_active_reg, line_active_next;
    logic [3:0] advance_channel;
    logic [7:0] line_byte;

    mask_next_channel u_next (
        .current      (channel_reg),
        .mask         (CHANNEL_MASK),
        .next_channel (advance_channel)
    );

    always_comb begin
        case (index_reg)
            3'd0:    line_byte = hex_ascii(channel_reg);
            3'd1:    line_byte = ASCII_COLON;
            3'd2:    line_byte = hex_ascii({2'b00, sample_reg[9:8]});
            3'd3:    line_byte = hex_ascii(sample_reg[7:4]);
            3'd4:    line_byte = hex_ascii(sample_reg[3:0]);
            3'd5:    line_byte = ASCII_CR;
            default: line_byte = ASCII_LF;
        endcase
    end

    always_comb begin
        state_next       = state_reg;
        index_next       = index_reg;
        sample_next      = sample_reg;
        channel_next     = channel_reg;
        tx_data_next     = tx_data_reg;
        new_tx_data_next = 1'b0;
        line_active_next = line_active_reg;
        case (state_reg)
            ST_WAIT: begin
                if (enable && (CHANNEL_MASK != 16'h0000) && new_sample &&
                    (sample_channel == channel_reg)) begin
                    sample_next      = sample;
                    index_next       = 3'd0;
                    line_active_next = 1'b1;
                    state_next       = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!tx_busy) begin
                    tx_data_next     = line_byte;
                    new_tx_data_next = 1'b1;
                    state_next       = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (index_reg < LAST_INDEX) begin
                    index_next = index_reg + 3'd1;
                    state_next = ST_SEND;
                end else begin
                    line_active_next = 1'b0;
                    channel_next     = advance_channel;
                    state_next       = ST_WAIT;
                end
            end
            default: state_next = ST_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_WAIT;
            index_reg       <= 3'd0;
            sample_reg      <= 10'd0;
            channel_reg     <= FIRST_CHANNEL;
            tx_data_reg     <= 8'h00;
            new_tx_data_reg <= 1'b0;
            line_active_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            index_reg       <= index_next;
            sample_reg      <= sample_next;
            channel_reg     <= channel_next;
            tx_data_reg     <= tx_data_next;
            new_tx_data_reg <= new_tx_data_next;
            line_active_reg <= line_active_next;
        end
    end

    assign channel     = channel_reg;
    assign tx_data     = tx_data_reg;
    assign new_tx_data = new_tx_data_reg;
    assign line_active = line_active_reg;

endmodule

// File: tb/tb_adc_line_reporter.sv
// Directed bench for adc_line_reporter: two instances (masks 0005 and 8001)
// driven on the falling edge and observed on the falling edge.
module tb_adc_line_reporter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       new_sample;
    logic [9:0] sample;
    logic [3:0] sample_channel;
    logic       tx_busy;

    logic       enable_a, enable_b;
    logic [3:0] channel_a, channel_b;
    logic [7:0] tx_data_a, tx_data_b;
    logic       ntx_a, ntx_b;
    logic       line_active_a, line_active_b;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    adc_line_reporter #(.CHANNEL_MASK(16'h0005)) dut_a (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable_a),
        .channel        (channel_a),
        .new_sample     (new_sample),
        .sample         (sample),
        .sample_channel (sample_channel),
        .tx_data        (tx_data_a),
        .new_tx_data    (ntx_a),
        .tx_busy        (tx_busy),
        .line_active    (line_active_a)
    );

    adc_line_reporter #(.CHANNEL_MASK(16'h8001)) dut_b (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable_b),
        .channel        (channel_b),
        .new_sample     (new_sample),
        .sample         (sample),
        .sample_channel (sample_channel),
        .tx_data        (tx_data_b),
        .new_tx_data    (ntx_b),
        .tx_busy        (tx_busy),
        .line_active    (line_active_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
            $display("check %s: observed %0h expected %0h ok", tag, obs, exp);
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_sample(input logic [3:0] ch, input logic [9:0] val);
        sample_channel = ch;
        sample         = val;
        new_sample     = 1'b1;
        @(negedge clk);
        new_sample     = 1'b0;
    endtask

    // Waits for pulses first..last of a line; byte i of line sits at bits [55-8i -: 8].
    task automatic recv_bytes(input bit sel, input logic [55:0] line, input int first,
                              input int last, input int first_gap, input string tag);
        for (int i = first; i <= last; i++) begin
            int  waited;
            bit  seen;
            waited = 0;
            seen   = 1'b0;
            while (!seen && waited < 20) begin
                @(negedge clk);
                waited++;
                if (sel ? ntx_b : ntx_a) seen = 1'b1;
            end
            chk($sformatf("%s_b%0d_seen", tag, i), 32'(seen), 32'd1);
            if (seen) begin
                chk($sformatf("%s_b%0d_gap", tag, i), 32'(waited),
                    32'((i == first) ? first_gap : 2));
                chk($sformatf("%s_b%0d_data", tag, i), 32'(sel ? tx_data_b : tx_data_a),
                    32'(line[55 - 8*i -: 8]));
                if (i == first)
                    chk($sformatf("%s_active", tag), 32'(sel ? line_active_b : line_active_a),
                        32'd1);
            end
        end
    endtask

    initial begin
        int pulses;
        rst_n = 1'b0; new_sample = 1'b0; sample = '0; sample_channel = '0;
        tx_busy = 1'b0; enable_a = 1'b0; enable_b = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_channel", 32'(channel_a), 32'h0);
        chk("rst_ntx", 32'(ntx_a), 32'h0);
        chk("rst_txdata", 32'(tx_data_a), 32'h00);
        chk("rst_active", 32'(line_active_a), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // ch0, 0x2A5 -> "0:2A5\r\n", then channel advances to 2
        enable_a = 1'b1;
        send_sample(4'd0, 10'h2A5);
        recv_bytes(1'b0, 56'h30_3A_32_41_35_0D_0A, 0, 6, 1, "l1");
        @(negedge clk);
        chk("l1_next_channel", 32'(channel_a), 32'h2);
        chk("l1_done_active", 32'(line_active_a), 32'h0);

        // Non-matching strobe is ignored
        send_sample(4'd3, 10'h155);
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (ntx_a) pulses++;
        end
        chk("nomatch_pulses", 32'(pulses), 32'd0);
        chk("nomatch_active", 32'(line_active_a), 32'h0);
        chk("nomatch_channel", 32'(channel_a), 32'h2);

        // ch2, 0x001 with tx_busy held high 50 cycles after the 2nd byte
        send_sample(4'd2, 10'h001);
        recv_bytes(1'b0, 56'h32_3A_30_30_31_0D_0A, 0, 1, 1, "l2");
        tx_busy = 1'b1;
        pulses = 0;
        repeat (50) begin
            @(negedge clk);
            if (ntx_a) pulses++;
        end
        chk("busy_pulses", 32'(pulses), 32'd0);
        chk("busy_txdata", 32'(tx_data_a), 32'h3A);
        tx_busy = 1'b0;
        recv_bytes(1'b0, 56'h32_3A_30_30_31_0D_0A, 2, 6, 1, "l2");
        @(negedge clk);
        chk("l2_wrap_channel", 32'(channel_a), 32'h0);

        // Mask 8001: enable low ignores matching samples
        enable_a = 1'b0;
        send_sample(4'd0, 10'h3FF);
        repeat (3) @(negedge clk);
        chk("dis_active_b", 32'(line_active_b), 32'h0);
        chk("dis_channel_b", 32'(channel_b), 32'h0);
        enable_b = 1'b1;
        send_sample(4'd0, 10'h000);
        recv_bytes(1'b1, 56'h30_3A_30_30_30_0D_0A, 0, 6, 1, "b0");
        @(negedge clk);
        chk("b0_next_channel", 32'(channel_b), 32'hF);
        send_sample(4'd15, 10'h3FF);
        recv_bytes(1'b1, 56'h46_3A_33_46_46_0D_0A, 0, 6, 1, "b15");
        @(negedge clk);
        chk("b15_wrap_channel", 32'(channel_b), 32'h0);
        enable_b = 1'b0;

        // Reset mid-line on ch2, then restart on ch0
        enable_a = 1'b1;
        send_sample(4'd0, 10'h2A5);
        recv_bytes(1'b0, 56'h30_3A_32_41_35_0D_0A, 0, 6, 1, "l3");
        @(negedge clk);
        chk("l3_next_channel", 32'(channel_a), 32'h2);
        send_sample(4'd2, 10'h0C3);
        recv_bytes(1'b0, 56'h32_3A_30_43_33_0D_0A, 0, 2, 1, "l4");
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ntx", 32'(ntx_a), 32'h0);
        chk("arst_txdata", 32'(tx_data_a), 32'h00);
        chk("arst_active", 32'(line_active_a), 32'h0);
        chk("arst_channel", 32'(channel_a), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_sample(4'd0, 10'h2A5);
        recv_bytes(1'b0, 56'h30_3A_32_41_35_0D_0A, 0, 6, 1, "l5");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
